// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// fpu_arbiter : round-robin front end sharing one FPU between two requesters
// Rev 1.0
// ============================================================================
module fpu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [1:0]  r0_op,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  output logic [31:0] r0_rsp_data,
  output logic        r0_rsp_err,
  // requester 1
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [1:0]  r1_op,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  output logic [31:0] r1_rsp_data,
  output logic        r1_rsp_err,
  // shared fpu
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  input  logic [31:0] fpu_out,
  output logic        busy
);

  localparam logic [1:0] c_OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_last_grant;
  logic [31:0] r_fpu_a;
  logic [31:0] r_fpu_b;
  logic [1:0]  r_fpu_op;
  logic [31:0] r_result;
  logic        r_err;

  logic        w_grant;
  logic        w_sel;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [1:0]  w_sel_op;
  logic        w_owner_rsp_ready;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    w_sel    = (r0_valid && r1_valid) ? ~r_last_grant : r1_valid;
    w_sel_a  = w_sel ? r1_a  : r0_a;
    w_sel_b  = w_sel ? r1_b  : r0_b;
    w_sel_op = w_sel ? r1_op : r0_op;
    w_owner_rsp_ready = r_owner ? r1_rsp_ready : r0_rsp_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r0_valid || r1_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = (w_sel_op == c_OP_DIV) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_RESP;
      S_RESP: begin
        if (w_owner_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Unsupported ops never reach the fpu, so its operand bus keeps the last issued op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_fpu_a      <= 32'd0;
      r_fpu_b      <= 32'd0;
      r_fpu_op     <= 2'd0;
      r_result     <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner      <= w_sel;
        r_last_grant <= w_sel;
        if (w_sel_op == c_OP_DIV) begin
          r_result <= 32'd0;
          r_err    <= 1'b1;
        end else begin
          r_fpu_a  <= w_sel_a;
          r_fpu_b  <= w_sel_b;
          r_fpu_op <= w_sel_op;
          r_err    <= 1'b0;
        end
      end
      if (r_state == S_WAIT) begin
        r_result <= fpu_out;
      end
    end
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    r0_ready     = rst_n & w_grant & ~w_sel;
    r1_ready     = rst_n & w_grant &  w_sel;
    r0_rsp_valid = (r_state == S_RESP) & ~r_owner;
    r1_rsp_valid = (r_state == S_RESP) &  r_owner;
    r0_rsp_data  = r0_rsp_valid ? r_result : 32'd0;
    r1_rsp_data  = r1_rsp_valid ? r_result : 32'd0;
    r0_rsp_err   = r0_rsp_valid & r_err;
    r1_rsp_err   = r1_rsp_valid & r_err;
    busy         = (r_state != S_IDLE);
    fpu_a        = r_fpu_a;
    fpu_b        = r_fpu_b;
    fpu_op       = r_fpu_op;
  end

endmodule
`default_nettype wire
